// File: rtl/bsg_manycore_ret_pkg.sv
// Shared types for the manycore return endpoint: fence FSM states and the return packet layout.
// The packet declaration is a macro because its coordinate widths come from module parameters.
package bsg_manycore_ret_pkg;

  localparam int ret_pad_width_gp = 5;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eDRAIN = 2'd1,
    eDONE  = 2'd2
  } fence_state_e;

endpackage

`define BSG_MANYCORE_RET_PACKET_DECLARE(x_w, y_w) \
  typedef struct packed { \
    logic [bsg_manycore_ret_pkg::ret_pad_width_gp-1:0] pad; \
    logic [y_w-1:0] y_cord; \
    logic [x_w-1:0] x_cord; \
  } bsg_manycore_ret_packet_s

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO: data visible on v_o/data_o one cycle after enqueue.
// ready_o drops when full (no same-cycle bypass); yumi_i pops the head.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    enq, deq;

  assign ready_o = (cnt_q != cnt_width_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) wr_ptr_d = (wr_ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (enq & ~deq) cnt_d = cnt_q + 1'b1;
    else if (deq & ~enq) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_credit_counter.sv
// Outstanding-request counter: +1 on up, -1 on down, hold on both/neither; registered count.
// avail_o gates new sends below max_p; a decrement at zero holds and sets a sticky underflow flag.
module bsg_manycore_credit_counter #(
  parameter int max_p   = 16,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               avail_o,
  output logic               zero_o,
  output logic               err_underflow_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               err_q, err_d;

  assign count_o         = count_q;
  assign avail_o         = (count_q < width_p'(max_p));
  assign zero_o          = (count_q == '0);
  assign err_underflow_o = err_q;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (up_i & ~down_i) begin
      if (avail_o) count_d = count_q + 1'b1;
    end else if (down_i & ~up_i) begin
      if (zero_o) err_d = 1'b1;
      else        count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/bsg_manycore_ret_endpoint.sv
// Credit/fence endpoint: combinational send grant, 2+ cycle fence drain, 1-cycle ack queue under ret_ready_i.
// Optional stall counter enabled by BSG_MANYCORE_RET_ENDPOINT_STATS_EN (otherwise stall_cycles_o = 0).
module bsg_manycore_ret_endpoint
  import bsg_manycore_ret_pkg::*;
#(
  parameter  int x_cord_width_p      = 4,
  parameter  int y_cord_width_p      = 4,
  parameter  int max_out_credits_p   = 16,
  parameter  int ret_fifo_els_p      = 2,
  localparam int ret_packet_width_lp = ret_pad_width_gp + x_cord_width_p + y_cord_width_p,
  localparam int credit_width_lp     = $clog2(max_out_credits_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           out_v_i,
  output logic                           out_ready_o,
  output logic                           out_v_o,
  input  logic                           ready_i,
  input  logic                           fence_v_i,
  output logic                           fence_yumi_o,
  input  logic                           ret_v_i,
  input  logic [ret_packet_width_lp-1:0] ret_data_i,
  output logic                           ret_ready_o,
  input  logic                           commit_v_i,
  input  logic [x_cord_width_p-1:0]      commit_from_x_i,
  input  logic [y_cord_width_p-1:0]      commit_from_y_i,
  output logic                           commit_ready_o,
  output logic                           ret_v_o,
  output logic [ret_packet_width_lp-1:0] ret_data_o,
  input  logic                           ret_ready_i,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  output logic [credit_width_lp-1:0]     credits_o,
  output logic                           err_underflow_o,
  output logic [31:0]                    stall_cycles_o
);

  `BSG_MANYCORE_RET_PACKET_DECLARE(x_cord_width_p, y_cord_width_p);

  localparam int coord_width_lp = x_cord_width_p + y_cord_width_p;

  fence_state_e                state_q, state_d;
  logic                        send, credit_avail, credit_zero;
  logic                        enq_v, self_commit;
  logic [coord_width_lp-1:0]   head_coord;
  bsg_manycore_ret_packet_s    ret_pkt;
  logic                        unused_ret_data;

  // Ack contents are not inspected: every ack retires exactly one credit.
  assign unused_ret_data = ^ret_data_i;
  assign ret_ready_o     = 1'b1;

  assign send        = out_v_i & ready_i & credit_avail & (state_q == eIDLE) & ~fence_v_i;
  assign out_v_o     = send;
  assign out_ready_o = send;

  bsg_manycore_credit_counter #(
    .max_p  (max_out_credits_p),
    .width_p(credit_width_lp)
  ) credit_counter (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .up_i           (send),
    .down_i         (ret_v_i),
    .count_o        (credits_o),
    .avail_o        (credit_avail),
    .zero_o         (credit_zero),
    .err_underflow_o(err_underflow_o)
  );

  always_comb begin
    state_d      = state_q;
    fence_yumi_o = 1'b0;
    case (state_q)
      eIDLE:   if (fence_v_i) state_d = eDRAIN;
      eDRAIN:  if (credit_zero & ~ret_v_i) state_d = eDONE;
      eDONE: begin
        fence_yumi_o = 1'b1;
        state_d      = eIDLE;
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= eIDLE;
    else         state_q <= state_d;
  end

  // Self-originated commits are acknowledged locally, so they are consumed without queueing.
  assign self_commit = (commit_from_x_i == my_x_i) & (commit_from_y_i == my_y_i);
  assign enq_v       = commit_v_i & commit_ready_o & ~self_commit;

  bsg_fifo_1r1w_small #(
    .width_p(coord_width_lp),
    .els_p  (ret_fifo_els_p)
  ) ack_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (enq_v),
    .ready_o(commit_ready_o),
    .data_i ({commit_from_y_i, commit_from_x_i}),
    .v_o    (ret_v_o),
    .data_o (head_coord),
    .yumi_i (ret_v_o & ret_ready_i)
  );

  always_comb begin
    ret_pkt        = '0;
    ret_pkt.y_cord = head_coord[coord_width_lp-1:x_cord_width_p];
    ret_pkt.x_cord = head_coord[x_cord_width_p-1:0];
  end
  assign ret_data_o = ret_pkt;

`ifdef BSG_MANYCORE_RET_ENDPOINT_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_cond;

  assign stall_cond = out_v_i & ready_i & (credits_o == credit_width_lp'(max_out_credits_p))
                    & (state_q == eIDLE) & ~fence_v_i;

  always_comb begin
    stall_d = stall_q;
    if (stall_cond && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

  commit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(commit_v_i && !commit_ready_o))
    else $error("commit_v_i asserted while commit_ready_o is low; commit dropped");

endmodule

// File: tb/tb_bsg_manycore_ret_endpoint.sv
// Directed test-plan scenarios plus a random phase, all checked against a queue/counter model.
module tb_bsg_manycore_ret_endpoint;

  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int MAX  = 4;
  localparam int ELS  = 2;
  localparam int PW   = 5 + XW + YW;
  localparam int CW   = $clog2(MAX + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          out_v_i = 0, ready_i = 0, fence_v_i = 0, ret_v_i = 0;
  logic [PW-1:0] ret_data_i = '0;
  logic          commit_v_i = 0, ret_ready_i = 0;
  logic [XW-1:0] commit_from_x_i = '0, my_x_i = 4'd1;
  logic [YW-1:0] commit_from_y_i = '0, my_y_i = 4'd1;
  logic          out_ready_o, out_v_o, fence_yumi_o, ret_ready_o, commit_ready_o, ret_v_o, err_underflow_o;
  logic [PW-1:0] ret_data_o;
  logic [CW-1:0] credits_o;
  logic [31:0]   stall_cycles_o;

  bsg_manycore_ret_endpoint #(
    .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_out_credits_p(MAX), .ret_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .out_v_i(out_v_i), .out_ready_o(out_ready_o), .out_v_o(out_v_o), .ready_i(ready_i),
    .fence_v_i(fence_v_i), .fence_yumi_o(fence_yumi_o),
    .ret_v_i(ret_v_i), .ret_data_i(ret_data_i), .ret_ready_o(ret_ready_o),
    .commit_v_i(commit_v_i), .commit_from_x_i(commit_from_x_i), .commit_from_y_i(commit_from_y_i),
    .commit_ready_o(commit_ready_o), .ret_v_o(ret_v_o), .ret_data_o(ret_data_o), .ret_ready_i(ret_ready_i),
    .my_x_i(my_x_i), .my_y_i(my_y_i),
    .credits_o(credits_o), .err_underflow_o(err_underflow_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outstanding count, sticky error, fence phase (0 idle, 1 draining, 2 done), ack queue.
  int          m_cnt, m_phase;
  bit          m_err;
  logic [7:0]  m_q[$];
  logic [31:0] m_stall;

  int          n_vec = 0, n_bad = 0;
  logic        last_grant, last_yumi, last_fire;
  logic [PW-1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_err = 0; m_stall = 0;
    m_q.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_credits", 32'(credits_o), 0);
    chk("rst_err", 32'(err_underflow_o), 0);
    chk("rst_yumi", 32'(fence_yumi_o), 0);
    chk("rst_ret_v", 32'(ret_v_o), 0);
    chk("rst_commit_rdy", 32'(commit_ready_o), 1);
    chk("rst_stall", stall_cycles_o, 0);
    chk("ret_ready", 32'(ret_ready_o), 1);
  endtask

  task automatic do_reset();
    reset_i = 1; out_v_i = 0; ready_i = 0; fence_v_i = 0; ret_v_i = 0;
    commit_v_i = 0; ret_ready_i = 0;
    @(posedge clk_i);
    model_reset();
    #1 reset_i = 0;
    #1 check_reset_values();
  endtask

  // One clock: drive inputs, compare combinational/registered outputs to the model, advance model at the edge.
  task automatic step(input logic ov, rdy, fv, rv, cv, input logic [3:0] cx, cy, input logic rr);
    logic e_grant, e_yumi, e_cr, e_rv, enq, deq;
    out_v_i = ov; ready_i = rdy; fence_v_i = fv; ret_v_i = rv; ret_data_i = PW'($urandom);
    commit_v_i = cv; commit_from_x_i = cx; commit_from_y_i = cy; ret_ready_i = rr;
    #1;
    e_grant = ov && rdy && (m_cnt < MAX) && (m_phase == 0) && !fv;
    e_yumi  = (m_phase == 2);
    e_cr    = (m_q.size() < ELS);
    e_rv    = (m_q.size() != 0);
    chk("out_ready", 32'(out_ready_o), 32'(e_grant));
    chk("out_v", 32'(out_v_o), 32'(e_grant));
    chk("credits", 32'(credits_o), 32'(m_cnt));
    chk("err_underflow", 32'(err_underflow_o), 32'(m_err));
    chk("fence_yumi", 32'(fence_yumi_o), 32'(e_yumi));
    chk("commit_ready", 32'(commit_ready_o), 32'(e_cr));
    chk("ret_v", 32'(ret_v_o), 32'(e_rv));
    if (e_rv) chk("ret_data", 32'(ret_data_o), {19'b0, 5'b0, m_q[0]});
`ifdef BSG_MANYCORE_RET_ENDPOINT_STATS_EN
    chk("stall", stall_cycles_o, m_stall);
`else
    chk("stall", stall_cycles_o, 0);
`endif
    last_grant = out_ready_o; last_yumi = fence_yumi_o;
    last_fire = ret_v_o & rr; last_data = ret_data_o;
    @(posedge clk_i);
    if (ov && rdy && m_cnt == MAX && m_phase == 0 && !fv && m_stall != 32'hFFFF_FFFF) m_stall++;
    case (m_phase)
      0: if (fv) m_phase = 1;
      1: if (m_cnt == 0 && !rv) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (e_grant && !rv) m_cnt++;
    else if (rv && !e_grant) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    deq = e_rv && rr;
    enq = cv && e_cr && !(cx == 4'(my_x_i) && cy == 4'(my_y_i));
    if (deq) void'(m_q.pop_front());
    if (enq) m_q.push_back({cy, cx});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int grants, yumi_at;
    logic [PW-1:0] seen [3];
    int nseen;
    bit fence_hold;
    logic cv;

    model_reset();
    do_reset();

    // Credit limit: 6 back-to-back requests, only MAX granted.
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      grants += int'(last_grant);
    end
    chk("limit_grants", 32'(grants), 4);
    chk("limit_credits", 32'(credits_o), 4);
    chk("limit_blocked", 32'(out_ready_o), 0);
`ifdef BSG_MANYCORE_RET_ENDPOINT_STATS_EN
    chk("limit_stall", stall_cycles_o, 2);
`endif

    // Simultaneous send and ack holds the count; ack at zero sets the sticky error.
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("simul_credits", 32'(credits_o), 2);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("underflow_credits", 32'(credits_o), 0);
    chk("underflow_flag", 32'(err_underflow_o), 1);

    // Fence drain from count 3 with acks on alternate cycles.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
    yumi_at = -1;
    for (int i = 0; i < 12 && yumi_at < 0; i++) begin
      step(1, 1, 1, (i < 6 && i % 2 == 0), 0, 0, 0, 0);
      if (last_grant) chk("fence_no_grant", 32'(last_grant), 0);
      if (last_yumi) yumi_at = i;
    end
    chk("fence_yumi_cycle", 32'(yumi_at), 6);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("fence_resume", 32'(last_grant), 1);

    // Ack backpressure and FIFO ordering.
    do_reset();
    step(0, 0, 0, 0, 1, 4'd1, 4'd2, 0);
    step(0, 0, 0, 0, 1, 4'd3, 4'd0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_full", 32'(commit_ready_o), 0);
    nseen = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    if (last_fire) begin seen[nseen] = last_data; nseen++; end
    step(0, 0, 0, 0, 1, 4'd2, 4'd2, 1);
    if (last_fire && nseen < 3) begin seen[nseen] = last_data; nseen++; end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    if (last_fire && nseen < 3) begin seen[nseen] = last_data; nseen++; end
    chk("bp_count", 32'(nseen), 3);
    if (nseen == 3) begin
      chk("bp_data0", 32'(seen[0]), 32'h021);
      chk("bp_data1", 32'(seen[1]), 32'h003);
      chk("bp_data2", 32'(seen[2]), 32'h022);
    end

    // Self-originated commit is accepted but never queued.
    do_reset();
    step(0, 0, 0, 0, 1, 4'd1, 4'd1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("self_ret_v", 32'(last_fire), 0);
    chk("self_ready", 32'(commit_ready_o), 1);

    // Reset while draining with two queued acks.
    do_reset();
    step(1, 1, 0, 0, 1, 4'd2, 4'd0, 0);
    step(1, 1, 0, 0, 1, 4'd0, 4'd3, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);

    // Random phase with the fence held until its acknowledge.
    fence_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!fence_hold && $urandom_range(0, 24) == 0) fence_hold = 1;
      cv = (m_q.size() < ELS) && ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, fence_hold,
           (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0),
           cv, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1));
      if (last_yumi) fence_hold = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
